// File: rtl/button_conditioner.sv
// Input front end for the player controller: synchronizes and debounces the start/up/down pads,
// and holds start/up presses as events until the next game_tick[0] consumes them.
module button_conditioner #(
   parameter int DB_CYCLES = 1000,
   parameter int CNT_W     = 10,
   parameter int REPEAT_UP = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_tick,
   input  logic       btn_start_raw,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   output logic       button_start,
   output logic       button_up,
   output logic       button_down,
   output logic [2:0] pressed
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);
   localparam logic             REPEAT_EN = (REPEAT_UP != 0);

   logic [2:0] raw;
   logic [2:0] stable_lvl;
   logic [1:0] rise;
   logic       unused_tick;

   assign raw         = {btn_down_raw, btn_up_raw, btn_start_raw};
   assign unused_tick = game_tick[1];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic             sync1_q, sync1_d;
         logic             sync2_q, sync2_d;
         logic             stable_q, stable_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // Any return to the current level restarts the count, so short glitches never flip it.
         always_comb begin
            sync1_d  = raw[gi];
            sync2_d  = sync1_q;
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (sync2_q == stable_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               stable_d = sync2_q;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_q  <= 1'b0;
               sync2_q  <= 1'b0;
               stable_q <= 1'b0;
               cnt_q    <= '0;
            end else begin
               sync1_q  <= sync1_d;
               sync2_q  <= sync2_d;
               stable_q <= stable_d;
               cnt_q    <= cnt_d;
            end
         end

         assign stable_lvl[gi] = stable_q;

         // Only start and up feed event latches; the rise is taken from the next-state value
         // so the latch sets on the same edge the debounced level goes high.
         if (gi < 2) begin : g_rise
            assign rise[gi] = stable_d & ~stable_q;
         end
      end
   endgenerate

   logic start_latch_q, start_latch_d;
   logic up_latch_q, up_latch_d;

   // Set wins over a coincident tick so a press landing on a tick edge is still reported.
   always_comb begin
      start_latch_d = start_latch_q;
      up_latch_d    = up_latch_q;
      if (game_tick[0]) begin
         start_latch_d = 1'b0;
         up_latch_d    = 1'b0;
      end
      if (rise[0]) start_latch_d = 1'b1;
      if (rise[1]) up_latch_d    = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_latch_q <= 1'b0;
         up_latch_q    <= 1'b0;
      end else begin
         start_latch_q <= start_latch_d;
         up_latch_q    <= up_latch_d;
      end
   end

   assign button_start = start_latch_q;
   assign button_up    = up_latch_q | (REPEAT_EN & stable_lvl[1]);
   assign button_down  = stable_lvl[2];
   assign pressed      = stable_lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4: one instance with auto-repeat on up,
// one without, both driven from the same pads and tick.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] game_tick;
   logic       btn_start_raw, btn_up_raw, btn_down_raw;
   logic       bs0, bu0, bd0;
   logic       bs1, bu1, bd1;
   logic [2:0] pr0, pr1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   button_conditioner #(.DB_CYCLES(4), .CNT_W(3), .REPEAT_UP(0)) dut0 (
      .clk(clk), .rst(rst), .game_tick(game_tick),
      .btn_start_raw(btn_start_raw), .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
      .button_start(bs0), .button_up(bu0), .button_down(bd0), .pressed(pr0)
   );

   button_conditioner #(.DB_CYCLES(4), .CNT_W(3), .REPEAT_UP(1)) dut1 (
      .clk(clk), .rst(rst), .game_tick(game_tick),
      .btn_start_raw(btn_start_raw), .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
      .button_start(bs1), .button_up(bu1), .button_down(bd1), .pressed(pr1)
   );

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      game_tick = 2'b00;
      btn_start_raw = 1'b0;
      btn_up_raw = 1'b0;
      btn_down_raw = 1'b0;
      step(2);
      check_eq("reset_outs0", {4'b0, bs0, bu0, bd0, 1'b0}, 8'h00);
      check_eq("reset_outs1", {4'b0, bs1, bu1, bd1, 1'b0}, 8'h00);
      check_eq("reset_pressed", {5'b0, pr1}, 8'h00);
      rst = 1'b0;
      step(2);

      // Start press: debounced and latched after edge 6, consumed by tick[0] only.
      btn_start_raw = 1'b1;
      step(5);
      check_eq("start_e5", {6'b0, pr1[0], bs1}, 8'h00);
      step(1);
      check_eq("start_e6", {6'b0, pr1[0], bs1}, 8'h03);
      check_eq("start_e6_dut0", {7'b0, bs0}, 8'h01);
      step(3);
      check_eq("start_held", {7'b0, bs1}, 8'h01);
      game_tick = 2'b10;
      step(1);
      check_eq("start_tick1_ignored", {7'b0, bs1}, 8'h01);
      game_tick = 2'b01;
      step(1);
      game_tick = 2'b00;
      check_eq("start_consumed", {6'b0, pr1[0], bs1}, 8'h02);
      step(3);
      check_eq("start_no_retrigger", {7'b0, bs1}, 8'h00);
      btn_start_raw = 1'b0;
      step(5);
      check_eq("start_rel_e5", {7'b0, pr1[0]}, 8'h01);
      step(1);
      check_eq("start_rel_e6", {7'b0, pr1[0]}, 8'h00);

      // Up glitches: 3-cycle pulse, then 1-cycle pulse; neither may get through.
      btn_up_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_eq("glitch3", {5'b0, pr1[1], bu1, bu0}, 8'h00);
      end
      btn_up_raw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         check_eq("glitch3_after", {5'b0, pr1[1], bu1, bu0}, 8'h00);
      end
      btn_up_raw = 1'b1;
      step(1);
      btn_up_raw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         check_eq("glitch1_after", {5'b0, pr1[1], bu1, bu0}, 8'h00);
      end

      // Up press without tick: event held after release, second press collapses.
      btn_up_raw = 1'b1;
      step(5);
      check_eq("up_e5", {6'b0, pr0[1], bu0}, 8'h00);
      step(1);
      check_eq("up_e6", {6'b0, pr0[1], bu0}, 8'h03);
      btn_up_raw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         check_eq("up_held_after_rel", {6'b0, bu1, bu0}, 8'h03);
      end
      check_eq("up_released_lvl", {7'b0, pr0[1]}, 8'h00);
      btn_up_raw = 1'b1;
      step(6);
      check_eq("up_second_press", {6'b0, pr0[1], bu0}, 8'h03);
      btn_up_raw = 1'b0;
      step(6);
      check_eq("up_second_rel", {6'b0, pr0[1], bu0}, 8'h01);
      game_tick = 2'b01;
      step(1);
      game_tick = 2'b00;
      check_eq("up_consumed", {6'b0, bu1, bu0}, 8'h00);
      step(4);
      check_eq("up_single_event", {6'b0, bu1, bu0}, 8'h00);

      // Up held across 5 tick periods: repeat instance stays high, one-shot instance drops.
      btn_up_raw = 1'b1;
      step(6);
      check_eq("rep_press", {6'b0, bu1, bu0}, 8'h03);
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < 4; c++) begin
            game_tick = (c == 3) ? 2'b01 : 2'b00;
            step(1);
            check_eq("rep_up1", {7'b0, bu1}, 8'h01);
            check_eq("rep_up0", {7'b0, bu0}, (p == 0 && c < 3) ? 8'h01 : 8'h00);
         end
      end
      game_tick = 2'b00;
      btn_up_raw = 1'b0;
      step(5);
      check_eq("rep_rel_e5", {7'b0, bu1}, 8'h01);
      step(1);
      check_eq("rep_rel_e6", {6'b0, pr1[1], bu1}, 8'h00);

      // Debounce completes on the same edge as a tick: set wins.
      btn_start_raw = 1'b1;
      step(5);
      game_tick = 2'b01;
      step(1);
      game_tick = 2'b00;
      check_eq("setwins", {6'b0, pr1[0], bs1}, 8'h03);
      step(2);
      check_eq("setwins_held", {7'b0, bs1}, 8'h01);
      game_tick = 2'b01;
      step(1);
      game_tick = 2'b00;
      check_eq("setwins_consumed", {7'b0, bs1}, 8'h00);
      btn_start_raw = 1'b0;
      step(6);
      check_eq("setwins_rel", {7'b0, pr1[0]}, 8'h00);

      // All pads held through reset.
      rst = 1'b1;
      btn_start_raw = 1'b1;
      btn_up_raw = 1'b1;
      btn_down_raw = 1'b1;
      step(2);
      check_eq("hold_rst", {3'b0, bs1, bu1, bd1, bs0, bu0}, 8'h00);
      rst = 1'b0;
      step(5);
      check_eq("hold_e5", {2'b0, bs1, bu1, bd1, pr1}, 8'h00);
      step(1);
      check_eq("hold_e6", {2'b0, bs1, bu1, bd1, pr1}, 8'h3f);
      check_eq("hold_e6_dut0", {6'b0, bs0, bu0}, 8'h03);

      // Asynchronous reset mid-cycle while both latches are set.
      #3;
      rst = 1'b1;
      #1;
      check_eq("async_rst", {2'b0, bs1, bu1, bd1, pr1}, 8'h00);
      check_eq("async_rst_dut0", {5'b0, bs0, bu0, bd0}, 8'h00);
      step(1);
      check_eq("async_rst_edge", {2'b0, bs1, bu1, bd1, pr1}, 8'h00);
      rst = 1'b0;
      step(5);
      check_eq("rehold_e5", {2'b0, bs1, bu1, bd1, pr1}, 8'h00);
      step(1);
      check_eq("rehold_e6", {2'b0, bs1, bu1, bd1, pr1}, 8'h3f);
      game_tick = 2'b01;
      step(1);
      game_tick = 2'b00;
      check_eq("rehold_consumed", {4'b0, bs1, bu1, bs0, bu0}, 8'h04);
      step(8);
      check_eq("rehold_one_event", {4'b0, bs1, bu1, bs0, bu0}, 8'h04);

      btn_start_raw = 1'b0;
      btn_up_raw = 1'b0;
      btn_down_raw = 1'b0;
      step(6);
      check_eq("final_idle", {4'b0, bd1, pr1}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
